// File: rtl/softmax_seq_ctrl_pkg.sv
// Shared types and defaults for the softmax sequencer: state encoding,
// default stage latencies and an elaboration-time latency sanity check.
package softmax_pkg;

    localparam int DEF_ADDRSIZE = 8;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_MAX_LAT  = 1;
    localparam int DEF_SUM_LAT  = 6;
    localparam int DEF_LN_LAT   = 4;
    localparam int DEF_OUT_LAT  = 3;

    typedef enum logic [3:0] {
        SM_IDLE,
        SM_MAX,
        SM_MAX_DRAIN,
        SM_SUM,
        SM_SUM_DRAIN,
        SM_LN,
        SM_OUT,
        SM_OUT_DRAIN,
        SM_DONE
    } sm_state_t;

    function automatic bit lat_ok(input int lat);
        return lat >= 1;
    endfunction

endpackage

// File: rtl/softmax_seq_ctrl_if.sv
// Control/handshake bundle between the softmax core top and its sequencer:
// job request, status pulses, the three read ports and the stage strobes.
interface softmax_seq_ctrl_if
    import softmax_pkg::*;
#(
    parameter int ADDRSIZE = DEF_ADDRSIZE
) ();
    logic                start;
    logic                abort;
    logic [ADDRSIZE-1:0] start_addr;
    logic [ADDRSIZE-1:0] end_addr;
    logic                busy;
    logic                done;
    logic                aborted;
    logic                max_rd;
    logic [ADDRSIZE-1:0] max_addr;
    logic                sub0_rd;
    logic [ADDRSIZE-1:0] sub0_addr;
    logic                sub1_rd;
    logic [ADDRSIZE-1:0] sub1_addr;
    logic                max_vld;
    logic                acc_clr;
    logic                sum_vld;
    logic                ln_start;
    logic                out_vld;
    logic [ADDRSIZE-1:0] out_addr;

    modport master (
        output start, abort, start_addr, end_addr,
        input  busy, done, aborted, max_rd, max_addr, sub0_rd, sub0_addr,
               sub1_rd, sub1_addr, max_vld, acc_clr, sum_vld, ln_start,
               out_vld, out_addr
    );

    modport slave (
        input  start, abort, start_addr, end_addr,
        output busy, done, aborted, max_rd, max_addr, sub0_rd, sub0_addr,
               sub1_rd, sub1_addr, max_vld, acc_clr, sum_vld, ln_start,
               out_vld, out_addr
    );
endinterface

// File: rtl/softmax_vld_pipe.sv
// Fixed-depth delay line for a valid bit plus an optional address payload;
// bit AW is the valid, bits AW-1:0 the address (AW may be 0).
module softmax_vld_pipe #(
    parameter int DEPTH = 1,
    parameter int AW    = 0
) (
    input  logic        clk,
    input  logic        flush_i,
    input  logic [AW:0] d_i,
    output logic [AW:0] q_o
);
    logic [AW:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (flush_i) begin
            // NOTE: this array is a handful of flops, not a RAM, so clearing every stage on flush is cheap and required.
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/softmax_seq_ctrl.sv
// Three-pass softmax sequencer: walks the operand range once per pass and
// times the drain/log waits with a single shared down-counter.
module softmax_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int ADDRSIZE = DEF_ADDRSIZE,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int MAX_LAT  = DEF_MAX_LAT,
    parameter int SUM_LAT  = DEF_SUM_LAT,
    parameter int LN_LAT   = DEF_LN_LAT,
    parameter int OUT_LAT  = DEF_OUT_LAT
) (
    input logic               clk,
    input logic               reset,
    softmax_seq_ctrl_if.slave ctrl
);
    localparam logic [3:0] S_IDLE      = SM_IDLE;
    localparam logic [3:0] S_MAX       = SM_MAX;
    localparam logic [3:0] S_MAX_DRAIN = SM_MAX_DRAIN;
    localparam logic [3:0] S_SUM       = SM_SUM;
    localparam logic [3:0] S_SUM_DRAIN = SM_SUM_DRAIN;
    localparam logic [3:0] S_LN        = SM_LN;
    localparam logic [3:0] S_OUT       = SM_OUT;
    localparam logic [3:0] S_OUT_DRAIN = SM_OUT_DRAIN;
    localparam logic [3:0] S_DONE      = SM_DONE;

    localparam int TOT = 3 * RD_LAT + MAX_LAT + SUM_LAT + LN_LAT + OUT_LAT;
    localparam int CW  = $clog2(TOT + 1);
    // Each wait state is entered with (length - 1) and leaves when the count hits zero.
    localparam logic [CW-1:0] MD_LOAD = CW'(RD_LAT + MAX_LAT - 1);
    localparam logic [CW-1:0] SD_LOAD = CW'(RD_LAT + SUM_LAT - 1);
    localparam logic [CW-1:0] LN_LOAD = CW'(LN_LAT - 1);
    localparam logic [CW-1:0] OD_LOAD = CW'(RD_LAT + OUT_LAT - 1);

    if (!(lat_ok(RD_LAT) && lat_ok(MAX_LAT) && lat_ok(SUM_LAT) &&
          lat_ok(LN_LAT) && lat_ok(OUT_LAT))) begin : g_bad_lat
        $error("softmax_seq_ctrl: every stage latency must be at least 1");
    end

    logic [3:0]          state_q, state_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d, base_q, base_d, end_q, end_d, addr_inc;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                aborted_q, abort_take, last_rd, cnt_zero, flush;
    logic                max_rd, sub0_rd, sub1_rd, max_vld, sum_vld;
    logic [ADDRSIZE:0]   out_pipe_q;

    assign abort_take = ctrl.abort && (state_q != S_IDLE);
    assign addr_inc   = addr_q + ADDRSIZE'(1);
    assign last_rd    = (addr_inc == end_q);
    assign cnt_zero   = (cnt_q == '0);
    assign flush      = reset || abort_take;

    always_comb begin
        // NOTE: defaults first so every path through the case assigns every next-state signal; no latches.
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (ctrl.start) begin
                base_d = ctrl.start_addr;
                end_d  = ctrl.end_addr;
                if (ctrl.end_addr > ctrl.start_addr) begin
                    state_d = S_MAX;
                    addr_d  = ctrl.start_addr;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_MAX: if (last_rd) begin
                state_d = S_MAX_DRAIN; addr_d = '0; cnt_d = MD_LOAD;
            end else addr_d = addr_inc;
            S_MAX_DRAIN: if (cnt_zero) begin
                state_d = S_SUM; addr_d = base_q;
            end else cnt_d = cnt_q - CW'(1);
            S_SUM: if (last_rd) begin
                state_d = S_SUM_DRAIN; addr_d = '0; cnt_d = SD_LOAD;
            end else addr_d = addr_inc;
            S_SUM_DRAIN: if (cnt_zero) begin
                state_d = S_LN; cnt_d = LN_LOAD;
            end else cnt_d = cnt_q - CW'(1);
            S_LN: if (cnt_zero) begin
                state_d = S_OUT; addr_d = base_q;
            end else cnt_d = cnt_q - CW'(1);
            S_OUT: if (last_rd) begin
                state_d = S_OUT_DRAIN; addr_d = '0; cnt_d = OD_LOAD;
            end else addr_d = addr_inc;
            S_OUT_DRAIN: if (cnt_zero) state_d = S_DONE;
                         else cnt_d = cnt_q - CW'(1);
            default: state_d = S_IDLE;
        endcase
        if (abort_take) begin
            state_d = S_IDLE; addr_d = '0; cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update together from pre-edge values.
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            base_q    <= '0;
            end_q     <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            end_q     <= end_d;
            cnt_q     <= cnt_d;
            aborted_q <= abort_take;
        end
    end

    assign max_rd  = (state_q == S_MAX);
    assign sub0_rd = (state_q == S_SUM);
    assign sub1_rd = (state_q == S_OUT);

    softmax_vld_pipe #(.DEPTH(RD_LAT), .AW(0)) u_max_pipe (
        .clk(clk), .flush_i(flush), .d_i(max_rd), .q_o(max_vld));
    softmax_vld_pipe #(.DEPTH(RD_LAT), .AW(0)) u_sum_pipe (
        .clk(clk), .flush_i(flush), .d_i(sub0_rd), .q_o(sum_vld));
    softmax_vld_pipe #(.DEPTH(RD_LAT + OUT_LAT), .AW(ADDRSIZE)) u_out_pipe (
        .clk(clk), .flush_i(flush), .d_i({sub1_rd, ctrl.sub1_addr}), .q_o(out_pipe_q));

    assign ctrl.busy      = (state_q != S_IDLE);
    assign ctrl.done      = (state_q == S_DONE);
    assign ctrl.aborted   = aborted_q;
    assign ctrl.acc_clr   = (state_q == S_IDLE) && ctrl.start;
    assign ctrl.max_rd    = max_rd;
    assign ctrl.sub0_rd   = sub0_rd;
    assign ctrl.sub1_rd   = sub1_rd;
    assign ctrl.max_addr  = max_rd  ? addr_q : '0;
    assign ctrl.sub0_addr = sub0_rd ? addr_q : '0;
    assign ctrl.sub1_addr = sub1_rd ? addr_q : '0;
    assign ctrl.max_vld   = max_vld;
    assign ctrl.sum_vld   = sum_vld;
    assign ctrl.ln_start  = (state_q == S_LN) && (cnt_q == LN_LOAD);
    assign ctrl.out_vld   = out_pipe_q[ADDRSIZE];
    assign ctrl.out_addr  = out_pipe_q[ADDRSIZE-1:0];
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Scoreboard bench for softmax_seq_ctrl: each accepted start pushes its full
// expected event timeline; a negedge monitor matches every observed strobe.
module tb_softmax_seq_ctrl;
    localparam int AW = 8;
    localparam int R = 1, M = 1, S = 6, L = 4, O = 3;

    localparam int K_ACC = 0, K_MAXRD = 1, K_SUB0RD = 2, K_SUB1RD = 3, K_MAXV = 4,
                   K_SUMV = 5, K_LN = 6, K_OUTV = 7, K_DONE = 8, K_ABT = 9;

    typedef struct {
        int cyc;
        int kind;
        int addr;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   cur_s = -10;
    int   cur_end = -10;
    ev_t  exp_q[$];

    softmax_seq_ctrl_if #(.ADDRSIZE(AW)) bus ();

    softmax_seq_ctrl #(
        .ADDRSIZE(AW), .RD_LAT(R), .MAX_LAT(M), .SUM_LAT(S), .LN_LAT(L), .OUT_LAT(O)
    ) dut (
        .clk(clk), .reset(reset), .ctrl(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_ACC:    return "acc_clr";
            K_MAXRD:  return "max_rd";
            K_SUB0RD: return "sub0_rd";
            K_SUB1RD: return "sub1_rd";
            K_MAXV:   return "max_vld";
            K_SUMV:   return "sum_vld";
            K_LN:     return "ln_start";
            K_OUTV:   return "out_vld";
            K_DONE:   return "done";
            default:  return "aborted";
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // Keep the queue ordered by (cycle, kind) so overdue entries sit at the front.
    task automatic ev_push(input int c, input int k, input int a);
        ev_t e;
        int  i;
        e.cyc = c; e.kind = k; e.addr = a;
        i = exp_q.size();
        while (i > 0 && (exp_q[i-1].cyc > c || (exp_q[i-1].cyc == c && exp_q[i-1].kind > k))) i--;
        exp_q.insert(i, e);
    endtask

    // Reference timeline: each pass is N reads, then the stated drain length.
    task automatic model_start(input int s, input int sa, input int ea);
        int n, t1, t2, t3, t4;
        if (s <= cur_end) return;
        n = (ea > sa) ? ea - sa : 0;
        cur_s = s;
        ev_push(s, K_ACC, 0);
        if (n == 0) begin
            cur_end = s + 1;
            ev_push(cur_end, K_DONE, 0);
            return;
        end
        t1 = s + 1;
        t2 = t1 + n + R + M;
        t3 = t2 + n + R + S;
        t4 = t3 + L;
        for (int i = 0; i < n; i++) begin
            ev_push(t1 + i, K_MAXRD, sa + i);
            ev_push(t1 + R + i, K_MAXV, 0);
            ev_push(t2 + i, K_SUB0RD, sa + i);
            ev_push(t2 + R + i, K_SUMV, 0);
            ev_push(t4 + i, K_SUB1RD, sa + i);
            ev_push(t4 + R + O + i, K_OUTV, sa + i);
        end
        ev_push(t3, K_LN, 0);
        cur_end = t4 + n + R + O;
        ev_push(cur_end, K_DONE, 0);
    endtask

    task automatic drop_after(input int c);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc > c) exp_q.delete(i);
    endtask

    task automatic model_abort(input int a);
        if (!(a > cur_s && a <= cur_end)) return;
        drop_after(a);
        ev_push(a + 1, K_ABT, 0);
        cur_end = a;
    endtask

    task automatic model_reset(input int r);
        drop_after(r);
        if (cur_end > r) cur_end = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_start(input int sa, input int ea);
        bus.start = 1'b1; bus.start_addr = AW'(sa); bus.end_addr = AW'(ea);
        model_start(cyc, sa, ea);
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        model_abort(cyc);
        step();
        bus.abort = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset(cyc);
        step();
        reset = 1'b0;
    endtask

    task automatic match_ev(input int k, input int a);
        int idx;
        idx = -1;
        foreach (exp_q[i])
            if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == k) idx = i;
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL unexpected_%s cycle=%0d got=1 exp=0 addr=%0d", kname(k), cyc, a);
        end else begin
            if (exp_q[idx].addr != a) begin
                bad++;
                $display("FAIL addr_%s cycle=%0d got=%0d exp=%0d", kname(k), cyc, a, exp_q[idx].addr);
            end
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        int stray;
        if (mon_en) begin
            if (bus.acc_clr)  match_ev(K_ACC, 0);
            if (bus.max_rd)   match_ev(K_MAXRD, int'(bus.max_addr));
            if (bus.sub0_rd)  match_ev(K_SUB0RD, int'(bus.sub0_addr));
            if (bus.sub1_rd)  match_ev(K_SUB1RD, int'(bus.sub1_addr));
            if (bus.max_vld)  match_ev(K_MAXV, 0);
            if (bus.sum_vld)  match_ev(K_SUMV, 0);
            if (bus.ln_start) match_ev(K_LN, 0);
            if (bus.out_vld)  match_ev(K_OUTV, int'(bus.out_addr));
            if (bus.done)     match_ev(K_DONE, 0);
            if (bus.aborted)  match_ev(K_ABT, 0);
            check("busy", int'(bus.busy), (cyc > cur_s && cyc <= cur_end) ? 1 : 0);
            stray = (bus.max_rd  ? 0 : int'(bus.max_addr))  | (bus.sub0_rd ? 0 : int'(bus.sub0_addr)) |
                    (bus.sub1_rd ? 0 : int'(bus.sub1_addr)) | (bus.out_vld ? 0 : int'(bus.out_addr));
            check("idle_addr_zero", stray, 0);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_%s cycle=%0d got=0 exp=1 addr=%0d",
                         kname(exp_q[0].kind), exp_q[0].cyc, exp_q[0].addr);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog cycle=%0d got=running exp=finished", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0, sa, ea, sel, ab_rel, ig_rel;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.start_addr = '0; bus.end_addr = '0;
        repeat (3) step();
        check("rst_strobes", int'({bus.busy, bus.done, bus.aborted, bus.max_rd, bus.sub0_rd,
              bus.sub1_rd, bus.max_vld, bus.acc_clr, bus.sum_vld, bus.ln_start, bus.out_vld}), 0);
        check("rst_addrs", int'(bus.max_addr | bus.sub0_addr | bus.sub1_addr | bus.out_addr), 0);
        reset = 1'b0;
        mon_en = 1'b1;
        step();

        // N=4 job, a start while busy, then a start right after done.
        s0 = cyc;
        pulse_start(4, 8);
        step_to(s0 + 10);
        pulse_start(1, 3);
        step_to(s0 + 31);
        pulse_start(10, 13);
        step_to(cur_end + 1);

        // Empty ranges and a single element.
        pulse_start(5, 5);
        step_to(cur_end + 1);
        pulse_start(9, 3);
        step_to(cur_end + 1);
        pulse_start(0, 1);
        step_to(cur_end + 1);

        // Abort during LN, then a normal job.
        s0 = cyc;
        pulse_start(4, 8);
        step_to(s0 + 20);
        pulse_abort();
        step_to(cur_end + 1);
        pulse_start(20, 23);
        step_to(cur_end + 1);

        // Reset during SUM_DRAIN, then a normal job.
        s0 = cyc;
        pulse_start(4, 8);
        step_to(s0 + 12);
        pulse_reset();
        step_to(cyc + 2);
        pulse_start(250, 255);
        step_to(cur_end + 1);

        // start and abort together in IDLE: start wins. Then abort alone in IDLE.
        bus.start = 1'b1; bus.abort = 1'b1; bus.start_addr = 8'd30; bus.end_addr = 8'd32;
        model_start(cyc, 30, 32);
        model_abort(cyc);
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        step_to(cur_end + 1);
        pulse_abort();
        step_to(cyc + 3);

        for (int j = 0; j < 14; j++) begin
            sa  = $urandom_range(0, 240);
            sel = $urandom_range(0, 9);
            if (sel == 0)      ea = sa;
            else if (sel == 1) ea = $urandom_range(0, sa);
            else               ea = sa + $urandom_range(1, 12);
            step_to(cur_end + 1 + $urandom_range(0, 3));
            s0 = cyc;
            pulse_start(sa, ea);
            ab_rel = ($urandom_range(0, 2) == 0) ? $urandom_range(1, cur_end - s0) : -1;
            ig_rel = $urandom_range(1, cur_end - s0);
            if (ab_rel < 0 || ig_rel < ab_rel) begin
                step_to(s0 + ig_rel);
                pulse_start($urandom_range(0, 100), $urandom_range(101, 200));
            end
            if (ab_rel > 0) begin
                step_to(s0 + ab_rel);
                pulse_abort();
            end
            step_to(cur_end + 1);
        end

        step_to(cur_end + 6);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
